// File: rtl/adder_arbiter_pkg.sv
// Shared types and round-robin helper for the adder arbiter.
// Used by the RTL and by the testbench.
package arb_pkg;

   typedef logic [0:0] state_t;

   localparam state_t EMPTY = 1'b0;
   localparam state_t FULL  = 1'b1;

   localparam int MAXREQ = 32;

   // One-hot grant: first set bit of valid, searching from last+1.
   function automatic logic [MAXREQ-1:0] rr_next(
      input int                n,
      input int                last,
      input logic [MAXREQ-1:0] valid
   );
      logic [MAXREQ-1:0] g;
      logic              found;
      logic [4:0]        ix;
      g     = '0;
      found = 1'b0;
      for (int k = 1; k <= MAXREQ; k++) begin
         if (k <= n) begin
            ix = 5'((last + k) % n);
            if (!found && valid[ix]) begin
               g[ix] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response bundle of the adder arbiter.
// slave = arbiter side, master = client side.
interface adder_arbiter_if #(
   parameter int N    = 16,
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [N-1:0]      rsp_sum;
   logic              rsp_carry;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );

endinterface

// File: rtl/adder.sv
// Shared combinational adder, no carry port.
module adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Y
);
   assign Y = A + B;
endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Combinational round-robin grant: one-hot plus binary index.
module rr_grant
   import arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [IDW-1:0]  i_last,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx
);
   logic [MAXREQ-1:0] w_full;

   assign w_full  = rr_next(NREQ, int'(i_last), MAXREQ'(i_valid));
   assign o_grant = w_full[NREQ-1:0];

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (o_grant[i]) o_idx = o_idx | IDW'(i);
      end
   end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters,
// one registered, id-tagged result per accepted request.
module adder_arbiter
   import arb_pkg::*;
#(
   parameter int N    = 16,
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   adder_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);

   state_t          r_state;
   logic [IDW-1:0]  r_last;
   logic [IDW-1:0]  r_id;
   logic [N-1:0]    r_sum;
   logic            r_carry;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_idx;
   logic            w_can_accept;
   logic            w_accept;
   logic            w_drain;
   logic [N-1:0]    w_a;
   logic [N-1:0]    w_b;
   logic [N-1:0]    w_y;

   rr_grant #(.NREQ(NREQ)) u_grant (
      .i_valid (bus.req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_drain      = (r_state == FULL) & bus.rsp_ready;
   assign w_can_accept = (r_state == EMPTY) | w_drain;

   assign bus.req_ready = (w_can_accept && !reset) ? w_grant : '0;
   assign w_accept      = |(bus.req_valid & bus.req_ready);

   assign w_a = bus.req_a[w_idx*N +: N];
   assign w_b = bus.req_b[w_idx*N +: N];

   adder #(.N(N)) u_adder (
      .A (w_a),
      .B (w_b),
      .Y (w_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= EMPTY;
         r_last  <= IDW'(NREQ - 1);
         r_id    <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_state <= FULL;
         r_last  <= w_idx;
         r_id    <= w_idx;
         r_sum   <= w_y;
         // wrap-around detect: carry out iff the sum fell below A
         r_carry <= (w_y < w_a);
      end else if (w_drain) begin
         r_state <= EMPTY;
      end
   end

   assign bus.rsp_valid = (r_state == FULL);
   assign bus.rsp_id    = r_id;
   assign bus.rsp_sum   = r_sum;
   assign bus.rsp_carry = r_carry;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed table-driven bench for adder_arbiter.
module tb_adder_arbiter;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   adder_arbiter_if #(.N(16), .NREQ(4)) bus ();

   adder_arbiter #(.N(16), .NREQ(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [63:0] a;
      logic [63:0] b;
      logic        rr;
      logic [3:0]  ex_rdy;
      logic        ex_vld;
      logic        chk;
      logic [1:0]  ex_id;
      logic [15:0] ex_sum;
      logic        ex_c;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(
      input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
      input logic rr, input logic [3:0] rdy, input logic vld,
      input logic chk, input logic [1:0] id, input logic [15:0] s,
      input logic c);
      vec_t t;
      t.v = v; t.a = a; t.b = b; t.rr = rr; t.ex_rdy = rdy;
      t.ex_vld = vld; t.chk = chk; t.ex_id = id; t.ex_sum = s;
      t.ex_c = c;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] AALL = {16'hf000, 16'h3000, 16'h2000, 16'h1000};
   localparam logic [63:0] BALL = {16'h2000, 16'h0300, 16'h0020, 16'h0001};
   localparam logic [63:0] Z    = 64'h0;

   initial begin
      n_chk  = 0;
      n_pass = 0;

      // all valid, round-robin from id 0
      tbl[0]  = mk(4'hf, AALL, BALL, 1, 4'b0001, 1, 1, 0, 16'h1001, 0);
      tbl[1]  = mk(4'hf, AALL, BALL, 1, 4'b0010, 1, 1, 1, 16'h2020, 0);
      tbl[2]  = mk(4'hf, AALL, BALL, 1, 4'b0100, 1, 1, 2, 16'h3300, 0);
      tbl[3]  = mk(4'hf, AALL, BALL, 1, 4'b1000, 1, 1, 3, 16'h1000, 1);
      tbl[4]  = mk(4'hf, AALL, BALL, 1, 4'b0001, 1, 1, 0, 16'h1001, 0);
      tbl[5]  = mk(4'hf, AALL, BALL, 1, 4'b0010, 1, 1, 1, 16'h2020, 0);
      tbl[6]  = mk(4'h0, Z, Z, 1, 4'b0000, 0, 0, 0, 16'h0, 0);
      // single request, requester 2
      tbl[7]  = mk(4'b0100, 64'h0000_fffe_0000_0000,
                   64'h0000_0001_0000_0000, 1, 4'b0100, 1, 1, 2, 16'hffff, 0);
      tbl[8]  = mk(4'h0, Z, Z, 1, 4'b0000, 0, 0, 0, 16'h0, 0);
      // wrap, requester 1
      tbl[9]  = mk(4'b0010, 64'h0000_0000_ffff_0000,
                   64'h0000_0000_0002_0000, 1, 4'b0010, 1, 1, 1, 16'h0001, 1);
      tbl[10] = mk(4'h0, Z, Z, 1, 4'b0000, 0, 0, 0, 16'h0, 0);
      // lone requester granted back to back
      tbl[11] = mk(4'b0010, 64'h0000_0000_0005_0000,
                   64'h0000_0000_0007_0000, 1, 4'b0010, 1, 1, 1, 16'h000c, 0);
      tbl[12] = mk(4'b0010, 64'h0000_0000_0005_0000,
                   64'h0000_0000_0007_0000, 1, 4'b0010, 1, 1, 1, 16'h000c, 0);
      tbl[13] = mk(4'h0, Z, Z, 1, 4'b0000, 0, 0, 0, 16'h0, 0);

      reset         = 1'b1;
      bus.req_valid = 4'hf;
      bus.req_a     = AALL;
      bus.req_b     = BALL;
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_sum", 32'(bus.rsp_sum), 32'h0);
      check("rst_id", 32'(bus.rsp_id), 32'h0);
      check("rst_carry", 32'(bus.rsp_carry), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         bus.req_valid = tbl[i].v;
         bus.req_a     = tbl[i].a;
         bus.req_b     = tbl[i].b;
         bus.rsp_ready = tbl[i].rr;
         #1;
         check($sformatf("row%0d_ready", i), 32'(bus.req_ready),
               32'(tbl[i].ex_rdy));
         tick();
         check($sformatf("row%0d_valid", i), 32'(bus.rsp_valid),
               32'(tbl[i].ex_vld));
         if (tbl[i].chk) begin
            check($sformatf("row%0d_id", i), 32'(bus.rsp_id),
                  32'(tbl[i].ex_id));
            check($sformatf("row%0d_sum", i), 32'(bus.rsp_sum),
                  32'(tbl[i].ex_sum));
            check($sformatf("row%0d_carry", i), 32'(bus.rsp_carry),
                  32'(tbl[i].ex_c));
         end
      end

      // backpressure: fill with id 0, then stall with 1 and 3 waiting
      bus.req_valid = 4'b0001;
      bus.req_a     = 64'h0000_0000_0000_0008;
      bus.req_b     = 64'h0000_0000_0000_0008;
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_fill_ready", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = 4'b1010;
      bus.req_a     = 64'h0300_0000_0100_0000;
      bus.req_b     = 64'h0003_0000_0001_0000;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'h0);
         check($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'h1);
         check($sformatf("bp%0d_id", c), 32'(bus.rsp_id), 32'h0);
         check($sformatf("bp%0d_sum", c), 32'(bus.rsp_sum), 32'h0010);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_rel_ready", 32'(bus.req_ready), 32'b0010);
      tick();
      check("bp_r1_id", 32'(bus.rsp_id), 32'h1);
      check("bp_r1_sum", 32'(bus.rsp_sum), 32'h0101);
      bus.req_valid = 4'b1000;
      #1;
      check("bp_r3_ready", 32'(bus.req_ready), 32'b1000);
      tick();
      check("bp_r3_id", 32'(bus.rsp_id), 32'h3);
      check("bp_r3_sum", 32'(bus.rsp_sum), 32'h0303);

      // asynchronous reset while a result is pending
      bus.req_valid = 4'b1001;
      bus.req_a     = 64'h0300_0000_0000_0040;
      bus.req_b     = 64'h0003_0000_0000_0002;
      bus.rsp_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
      tick();
      reset         = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      check("post_rst_ready", 32'(bus.req_ready), 32'b0001);
      tick();
      check("post_rst_valid", 32'(bus.rsp_valid), 32'h1);
      check("post_rst_id", 32'(bus.rsp_id), 32'h0);
      check("post_rst_sum", 32'(bus.rsp_sum), 32'h0042);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one N-bit `adder` instance among NREQ requesters.
- Requesters are served round-robin. Each requester issues operand pairs over a valid/ready handshake.
- The block registers one result per accepted request. Each result is tagged with the requester id and presented on a single valid/ready response port.
- Sits between datapath clients (address generation, ALU-side increment units) and the shared adder; the adder stays purely combinational.

Parameters:
- N, 16, operand/result width in bits.
- NREQ, 4, number of requesters, ≥2.
- IDW, $clog2(NREQ), requester id width (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair.
- req_a  input  NREQ*N  packed operand A, slice i = bits [i*N +: N].
- req_b  input  NREQ*N  packed operand B, same packing.
- req_ready  output  NREQ  one-hot or zero; bit i = requester i accepted this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_id  output  IDW  id of the requester that produced rsp_sum.
- rsp_sum  output  N  (a+b) mod 2^N.
- rsp_carry  output  1  unsigned carry-out of a+b.

Behaviour:
- Reset (async, immediate):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - req_ready is 0 while reset is high.
- FSM, 2 states:
  - EMPTY: result register invalid.
  - FULL: result register valid, waiting for rsp_ready.
  - Reset state is EMPTY.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready). Draining and accepting in the same cycle is allowed, so throughput is 1 result/cycle.
- Grant (combinational):
  - If can_accept and any req_valid, grant g = first set bit of req_valid, searching cyclically from (last+1) mod NREQ.
  - req_ready = one-hot(g). Otherwise req_ready=0.
  - req_ready never depends on rsp_ready through any path other than can_accept.
- Adder path: the mux selects req_a[g], req_b[g] into `adder`.
  - rsp_carry = (Y < A) unsigned comparison. The adder instance has no carry port, so carry is not computed with a wider add.
- Accept edge (req_valid[g] & req_ready[g]):
  - Register rsp_sum=Y, rsp_carry, rsp_id=g.
  - Set last=g and go to FULL.
  - Latency is 1 cycle: rsp_valid is high in the cycle after acceptance.
- Drain without accept: rsp_valid & rsp_ready with no grant → EMPTY. rsp_* data holds its last value but is don't-care.
- FULL & !rsp_ready:
  - rsp_valid, rsp_id, rsp_sum and rsp_carry hold stable.
  - req_ready=0 and last is unchanged.
- Requester rules:
  - Once req_valid[i] is high, it and its operands hold stable until req_ready[i].
  - A requester may deassert req_valid only after acceptance.
  - The arbiter keeps no per-requester storage.
- Fairness:
  - A continuously valid requester is granted within NREQ accepts.
  - A lone requester is granted every cycle.
- Pointer advances only on an actual accept, never on idle cycles.
- Overflow: sum wraps modulo 2^N. No saturation, no signed flag.
- Reset mid-operation: the pending result is discarded, rsp_valid drops immediately, and the pointer is restored. Requesters must re-present after reset.
- X-safety: req_a/req_b of non-granted requesters never reach the rsp_* registers.

Decomposition:
- Shared package arb_pkg:
  - typedef state_t {EMPTY, FULL}.
  - Function rr_next(last, valid) returning a one-hot grant, used by the RTL and by the bench scoreboard.
- Sub-module rr_grant (parameter NREQ): inputs valid and last, outputs a one-hot grant and the binary index. Purely combinational.
- The existing `adder` module is instantiated unchanged (ports A, B, Y), with parameter N.

Test Plan:
1. Reset with all req_valid high → req_ready=0, rsp_valid=0, rsp_sum=0. After release, the first grant goes to id 0.
2. Single request, requester 2, a=0xfffe, b=0x0001, rsp_ready=1 → req_ready=0b0100 that cycle. Next cycle: rsp_valid=1, rsp_id=2, rsp_sum=0xffff, rsp_carry=0.
3. Wrap: requester 1, a=0xffff, b=0x0002 → rsp_sum=0x0001, rsp_carry=1, rsp_id=1.
4. All 4 valid continuously with distinct operands, rsp_ready=1 → 1 result/cycle, rsp_id sequence 0,1,2,3,0,1. Each sum matches the scoreboard.
5. Backpressure: FULL with id 0 (sum 0x0010), rsp_ready=0 for 3 cycles, requesters 1 and 3 valid → outputs stable, req_ready=0. When rsp_ready=1, requester 1 is granted in that same cycle, then requester 3 on the next accept.
6. Reset asserted mid-cycle while rsp_valid=1 → rsp_valid=0 before the next clk edge. After release, requester 0 wins over requester 3 when both are valid.
